// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registers one command toward an external combinational ALU,
// captures the result and holds it as a response until the consumer takes it.
module alu_cmd_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_op,
    output logic       rsp_err,
    output logic [7:0] err_cnt
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ISSUE | operands on alu_*, result captured on the next edge
    // RESP  | response held on rsp_* until rsp_ready
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_op_q, rsp_op_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       div_zero;

    assign div_zero = (alu_op_q == OP_DIV) && (alu_b_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_op_d   = rsp_op_q;
        rsp_err_d  = rsp_err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // divide-by-zero overrides whatever the ALU produces
                rsp_data_d = div_zero ? 8'hFF : alu_out;
                rsp_op_d   = alu_op_q;
                rsp_err_d  = div_zero;
                if (div_zero && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_op_q   <= 2'd0;
            rsp_data_q <= 8'd0;
            rsp_op_q   <= 2'd0;
            rsp_err_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_op_q   <= rsp_op_d;
            rsp_err_q  <= rsp_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: random and directed commands against a queue-based
// reference of accepted commands and their expected responses.
module tb_alu_cmd_issuer;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] op;
        logic       err;
    } rsp_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_op;
    logic       rsp_err;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    bit mdl_on = 0;
    bit rand_bp = 0;

    rsp_t exp_q[$];
    int   acc_cyc_q[$];
    int   rsp_cyc_q[$];
    bit   issue_pend;
    logic [3:0] m_alu_a, m_alu_b;
    logic [1:0] m_alu_op, m_rsp_op;
    logic [7:0] m_rsp_data, m_err_cnt;
    logic       m_rsp_err;

    alu_cmd_issuer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // environment ALU; divide-by-zero returns junk the DUT must override
    always_comb begin
        alu_out = 8'h00;
        case (alu_op)
            2'd0: alu_out = {4'b0, alu_a} + {4'b0, alu_b};
            2'd1: alu_out = {4'b0, alu_a} * {4'b0, alu_b};
            2'd2: alu_out = {4'b0, alu_a} - {4'b0, alu_b};
            default: alu_out = (alu_b == 4'd0) ? 8'h5A : ({4'b0, alu_a} / {4'b0, alu_b});
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic rsp_t ref_rsp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        rsp_t r;
        int ia, ib, v;
        ia = int'(a);
        ib = int'(b);
        v = 0;
        r.op = op;
        r.err = 1'b0;
        case (op)
            2'd0: v = ia + ib;
            2'd1: v = ia * ib;
            2'd2: v = (ia - ib + 256) % 256;
            default: begin
                if (ib == 0) begin
                    v = 255;
                    r.err = 1'b1;
                end else begin
                    v = ia / ib;
                end
            end
        endcase
        r.data = 8'(v);
        return r;
    endfunction

    // compare what past edges produced, then decide what the coming edge does
    always @(negedge clk) begin
        cyc++;
        if (mdl_on) begin
            check("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() == 0));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0 && !issue_pend));
            check("alu_a", 32'(alu_a), 32'(m_alu_a));
            check("alu_b", 32'(alu_b), 32'(m_alu_b));
            check("alu_op", 32'(alu_op), 32'(m_alu_op));
            check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
            check("rsp_op", 32'(rsp_op), 32'(m_rsp_op));
            check("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
            check("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        end
        if (!rst_n) begin
            exp_q.delete();
            issue_pend = 0;
            m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
            m_rsp_data = '0; m_rsp_op = '0; m_rsp_err = 1'b0; m_err_cnt = '0;
            mdl_on = 1;
        end else if (mdl_on) begin
            if (issue_pend) begin
                m_rsp_data = exp_q[0].data;
                m_rsp_op   = exp_q[0].op;
                m_rsp_err  = exp_q[0].err;
                if (exp_q[0].err && m_err_cnt < 8'd255) m_err_cnt = m_err_cnt + 8'd1;
                issue_pend = 0;
            end else if (exp_q.size() != 0) begin
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    rsp_cnt++;
                    rsp_cyc_q.push_back(cyc);
                end
            end else if (cmd_valid) begin
                exp_q.push_back(ref_rsp(cmd_op, cmd_a, cmd_b));
                m_alu_a = cmd_a; m_alu_b = cmd_b; m_alu_op = cmd_op;
                issue_pend = 1;
                acc_cnt++;
                acc_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic junk_cmd();
        cmd_op = 2'($urandom);
        cmd_a  = 4'($urandom);
        cmd_b  = 4'($urandom);
    endtask

    task automatic accept_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (acc_cnt == start && n < 100) begin
            step();
            n++;
            if (rand_bp) rsp_ready = 1'($urandom);
        end
        check("accept_timeout", 32'(acc_cnt != start), 1);
        cmd_valid = 1'b0;
        junk_cmd();
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 200) begin
            step();
            n++;
            if (rand_bp) rsp_ready = 1'($urandom);
        end
        check("rsp_timeout", 32'(rsp_cnt >= target), 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int t;
        t = rsp_cnt + 1;
        accept_cmd(op, a, b);
        wait_rsp(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int a0, r0, n;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("reset_ready", 32'(cmd_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);

        send(2'd0, 4'd9, 4'd7);
        check("add_data", 32'(rsp_data), 32'h10);
        send(2'd1, 4'd15, 4'd15);
        check("mul_data", 32'(rsp_data), 32'hE1);
        send(2'd2, 4'd3, 4'd5);
        check("sub_data", 32'(rsp_data), 32'hFE);
        check("sub_err", 32'(rsp_err), 0);
        send(2'd3, 4'd14, 4'd3);
        check("div_data", 32'(rsp_data), 32'h04);
        send(2'd3, 4'd7, 4'd0);
        check("dz_data", 32'(rsp_data), 32'hFF);
        check("dz_err", 32'(rsp_err), 1);
        check("dz_cnt", 32'(err_cnt), 1);

        // backpressure with a competing command held on the input
        rsp_ready = 1'b0;
        accept_cmd(2'd2, 4'd3, 4'd5);
        step();
        cmd_op = 2'd0; cmd_a = 4'd9; cmd_b = 4'd7; cmd_valid = 1'b1;
        a0 = acc_cnt;
        repeat (5) step();
        check("bp_ready", 32'(cmd_ready), 0);
        check("bp_data", 32'(rsp_data), 32'hFE);
        check("bp_not_taken", acc_cnt, a0);
        rsp_ready = 1'b1;
        r0 = rsp_cnt;
        accept_cmd(2'd0, 4'd9, 4'd7);
        wait_rsp(r0 + 2);
        check("bp_after_data", 32'(rsp_data), 32'h10);

        for (int i = 0; i < 300; i++) send(2'd3, 4'($urandom), 4'd0);
        check("dz_sat", 32'(err_cnt), 255);
        repeat (3) step();
        check("dz_sat_hold", 32'(err_cnt), 255);

        // reset during ISSUE, then during RESP with a pending handshake
        accept_cmd(2'd1, 4'd6, 4'd7);
        cmd_valid = 1'b1;
        do_reset();
        cmd_valid = 1'b0;
        check("rst_issue_valid", 32'(rsp_valid), 0);
        check("rst_issue_cnt", 32'(err_cnt), 0);
        rsp_ready = 1'b0;
        accept_cmd(2'd3, 4'd5, 4'd0);
        step();
        rsp_ready = 1'b1;
        do_reset();
        check("rst_resp_valid", 32'(rsp_valid), 0);
        check("rst_resp_data", 32'(rsp_data), 0);
        check("rst_resp_ready", 32'(cmd_ready), 1);

        // back-to-back with valid held high
        acc_cyc_q.delete();
        rsp_cyc_q.delete();
        r0 = rsp_cnt;
        a0 = acc_cnt;
        cmd_op = 2'd0; cmd_a = 4'd1; cmd_b = 4'd2; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (acc_cnt == a0 + i && n < 20) begin step(); n++; end
            cmd_op = 2'(i + 1); cmd_a = 4'(i + 4); cmd_b = 4'(i + 1);
        end
        cmd_valid = 1'b0;
        wait_rsp(r0 + 4);
        check("b2b_acc_n", acc_cyc_q.size(), 4);
        check("b2b_rsp_n", rsp_cyc_q.size(), 4);
        for (int i = 1; i < acc_cyc_q.size(); i++)
            check("b2b_acc_gap", acc_cyc_q[i] - acc_cyc_q[i-1], 3);
        for (int i = 1; i < rsp_cyc_q.size(); i++)
            check("b2b_rsp_gap", rsp_cyc_q[i] - rsp_cyc_q[i-1], 3);

        rand_bp = 1;
        for (int i = 0; i < 150; i++) begin
            junk_cmd();
            repeat ($urandom_range(0, 2)) step();
            send(2'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom));
        end
        rand_bp = 0;
        rsp_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
